// File: rtl/multicycle_ctrl_exc.sv
// multicycle_ctrl_exc
//   Multicycle MIPS control FSM with a MemReady wait handshake, bus timeout,
//   precise exceptions (irq / overflow / undefined / bus), kernel-mode flag
//   and eret. Sits between the IR decode fields and the multicycle datapath.
// Ports
//   clk, reset (async, active-low)
//   OpCode/Funct            IR[31:26] / IR[5:0]
//   Overflow                ALU signed overflow, valid in EX
//   MemReady                memory completes the current access this cycle
//   Irq                     level interrupt request
//   PCWrite..PCorData       1-bit datapath strobes
//   RegDst/ALUSrcA/ALUSrcB/PCSource  2-bit selects; ALUOp 4-bit ALU control
//   ExcTaken/EPCWrite/EPCSrc exception vector load, EPC write, EPC source
//   ExcCause/KernelMode     registered last cause / privilege flag
//   StateOut                current state encoding
module multicycle_ctrl_exc #(
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter bit          IRQ_EN        = 1'b1,
  parameter bit          TRAP_OVERFLOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Overflow,
  input  logic       MemReady,
  input  logic       Irq,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic       PCorData,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       ExcTaken,
  output logic       EPCWrite,
  output logic       EPCSrc,
  output logic [1:0] ExcCause,
  output logic       KernelMode,
  output logic [3:0] StateOut
);

  typedef enum logic [3:0] {
    S_IF = 4'h0, S_ID = 4'h1, S_EX = 4'h2, S_MRD = 4'h3, S_WBL = 4'h4,
    S_MWR = 4'h5, S_WB = 4'h6, S_JR = 4'h7, S_EXC = 4'h8, S_ERT = 4'h9
  } state_e;

  typedef enum logic [1:0] {
    C_IRQ = 2'd0, C_OVF = 2'd1, C_UNDEF = 2'd2, C_BUS = 2'd3
  } cause_e;

  state_e      state_q, state_d;
  cause_e      pend_q, pend_d;   // cause latched on entry to EXC
  cause_e      cause_q, cause_d; // cause reported after EXC
  logic        kern_q, kern_d;
  logic [15:0] cnt_q, cnt_d;

  logic       is_r, is_shift, is_jr, is_eret, is_trap, legal, r_legal, op_legal;
  logic       mem_to, no_ext;
  logic [2:0] alu_lo;

  always_comb begin
    is_r     = (OpCode == 6'h00);
    is_shift = is_r && (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03);
    is_jr    = is_r && (Funct == 6'h08 || Funct == 6'h09);
    is_eret  = (OpCode == 6'h10) && (Funct == 6'h18);
    is_trap  = (is_r && (Funct == 6'h20 || Funct == 6'h22)) || (OpCode == 6'h08);
    no_ext   = (OpCode == 6'h0C) || (OpCode == 6'h0D);
    case (Funct)
      6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: r_legal = 1'b1;
      default:                                   r_legal = 1'b0;
    endcase
    case (OpCode)
      6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
      6'h0F, 6'h23, 6'h2B: op_legal = 1'b1;
      default:             op_legal = 1'b0;
    endcase
    legal = (is_r && r_legal) || op_legal || is_eret;
    case (OpCode)
      6'h00:        alu_lo = 3'b010;
      6'h04:        alu_lo = 3'b001;
      6'h0C, 6'h0D: alu_lo = 3'b100;
      6'h0A, 6'h0B: alu_lo = 3'b101;
      6'h09:        alu_lo = 3'b011;
      default:      alu_lo = 3'b000;
    endcase
    // Timeout fires on the (MEM_TIMEOUT+1)-th consecutive not-ready cycle
    mem_to = (MEM_TIMEOUT != 0) && (cnt_q == 16'(MEM_TIMEOUT)) && !MemReady;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      pend_q  <= C_IRQ;
      cause_q <= C_IRQ;
      kern_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      kern_q  <= kern_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cause_d = cause_q;
    kern_d  = kern_q;
    cnt_d   = '0;
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemWrite = 1'b0;
    MemRead = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    ExtOp = 1'b0; LuiOp = 1'b0; PCorData = 1'b0;
    RegDst = '0; ALUSrcA = '0; ALUSrcB = '0; PCSource = '0; ALUOp = '0;
    ExcTaken = 1'b0; EPCWrite = 1'b0; EPCSrc = 1'b0;
    StateOut   = state_q;
    ExcCause   = cause_q;
    KernelMode = kern_q;

    case (state_q)
      S_IF: begin
        ALUOp = {OpCode[0], 3'b000};
        // Interrupt sampled only on the entry cycle; no fetch is issued then
        if (cnt_q == '0 && IRQ_EN && Irq && !kern_q) begin
          state_d = S_EXC;
          pend_d  = C_IRQ;
        end else begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_ID;
          end else if (mem_to) begin
            state_d = S_EXC;
            pend_d  = C_BUS;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
          end
        end
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        ALUOp   = {OpCode[0], 3'b000};
        ExtOp   = !no_ext;
        LuiOp   = (OpCode == 6'h0F);
        if (!legal || (is_eret && !kern_q)) begin
          state_d = S_EXC;
          pend_d  = C_UNDEF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        ALUOp   = {OpCode[0], alu_lo};
        ExtOp   = !no_ext;
        LuiOp   = (OpCode == 6'h0F);
        state_d = S_IF;
        if (is_r) begin
          ALUSrcA = is_shift ? 2'b10 : 2'b01;
          if (is_jr) begin
            state_d = S_JR;
          end else if (is_trap && Overflow && TRAP_OVERFLOW) begin
            state_d = S_EXC;
            pend_d  = C_OVF;
          end else begin
            state_d = S_WB;
          end
        end else begin
          case (OpCode)
            6'h04: begin
              PCWriteCond = 1'b1; ALUSrcA = 2'b01; PCSource = 2'b01;
            end
            6'h02: begin
              PCWrite = 1'b1; PCSource = 2'b11;
            end
            6'h03: begin
              PCWrite = 1'b1; PCSource = 2'b11;
              RegWrite = 1'b1; RegDst = 2'b10; PCorData = 1'b1;
            end
            6'h10: state_d = S_ERT;
            6'h23: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; state_d = S_MRD; end
            6'h2B: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; state_d = S_MWR; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: begin
              ALUSrcA = 2'b01;
              ALUSrcB = 2'b10;
              if (is_trap && Overflow && TRAP_OVERFLOW) begin
                state_d = S_EXC;
                pend_d  = C_OVF;
              end else begin
                state_d = S_WB;
              end
            end
            default: state_d = S_IF;
          endcase
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_r ? 2'b01 : 2'b00;
        state_d  = S_IF;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)    state_d = S_WBL;
        else if (mem_to) begin state_d = S_EXC; pend_d = C_BUS; end
        else             cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
      end
      S_WBL: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_IF;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady)    state_d = S_IF;
        else if (mem_to) begin state_d = S_EXC; pend_d = C_BUS; end
        else             cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b01;
        if (Funct == 6'h09) begin
          RegWrite = 1'b1; RegDst = 2'b01; PCorData = 1'b1;
        end
        state_d = S_IF;
      end
      S_ERT: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        kern_d   = 1'b0;
        state_d  = S_IF;
      end
      S_EXC: begin
        PCWrite  = 1'b1;
        ExcTaken = 1'b1;
        EPCWrite = 1'b1;
        EPCSrc   = (pend_q != C_IRQ);
        cause_d  = pend_q;
        kern_d   = 1'b1;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset gates every output so an aborted bus access drops immediately
    if (!reset) begin
      PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemWrite = 1'b0;
      MemRead = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
      ExtOp = 1'b0; LuiOp = 1'b0; PCorData = 1'b0;
      RegDst = '0; ALUSrcA = '0; ALUSrcB = '0; PCSource = '0; ALUOp = '0;
      ExcTaken = 1'b0; EPCWrite = 1'b0; EPCSrc = 1'b0;
      ExcCause = '0; KernelMode = 1'b0; StateOut = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_exc.sv
// tb_multicycle_ctrl_exc
//   Directed scenarios followed by random instruction streams. The reference
//   model expands each instruction into its expected per-cycle state path and
//   strobe set, and tracks kernel mode and the last exception cause.
module tb_multicycle_ctrl_exc;

  localparam int unsigned TO = 15;

  localparam logic [3:0] ST_IF = 4'h0, ST_ID = 4'h1, ST_EX = 4'h2, ST_MRD = 4'h3,
                         ST_WBL = 4'h4, ST_MWR = 4'h5, ST_WB = 4'h6, ST_JR = 4'h7,
                         ST_EXC = 4'h8, ST_ERT = 4'h9;

  typedef struct packed {
    logic pcw, pcwc, iord, memw, memr, irw, m2r, regw, extop, luiop, pcord;
    logic [1:0] regdst, srca, srcb, pcsrc;
    logic [3:0] aluop;
    logic exct, epcw, epcsrc;
    logic [1:0] cause;
    logic km;
    logic [3:0] st;
  } obs_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [5:0] OpCode = '0, Funct = '0;
  logic Overflow = 1'b0, MemReady = 1'b0, Irq = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, MemtoReg, RegWrite;
  logic ExtOp, LuiOp, PCorData, ExcTaken, EPCWrite, EPCSrc, KernelMode;
  logic [1:0] RegDst, ALUSrcA, ALUSrcB, PCSource, ExcCause;
  logic [3:0] ALUOp, StateOut;

  int n_assert = 0, n_fail = 0;
  logic       m_km = 1'b0;
  logic [1:0] m_cause = '0;
  logic [5:0] cur_op = '0, cur_fn = '0;
  logic       cur_ov = 1'b0;

  multicycle_ctrl_exc #(.MEM_TIMEOUT(TO), .IRQ_EN(1'b1), .TRAP_OVERFLOW(1'b1)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Overflow(Overflow),
    .MemReady(MemReady), .Irq(Irq), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .PCorData(PCorData), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .ExcTaken(ExcTaken), .EPCWrite(EPCWrite),
    .EPCSrc(EPCSrc), .ExcCause(ExcCause), .KernelMode(KernelMode), .StateOut(StateOut)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A, 6'h2B};
    if (op == 6'h10) return fn == 6'h18;
    return op inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  endfunction

  function automatic logic [2:0] alu_lo(input logic [5:0] op);
    case (op)
      6'h00:        return 3'b010;
      6'h04:        return 3'b001;
      6'h0C, 6'h0D: return 3'b100;
      6'h0A, 6'h0B: return 3'b101;
      6'h09:        return 3'b011;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.km = m_km;
    o.cause = m_cause;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, MemtoReg, RegWrite,
          ExtOp, LuiOp, PCorData, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp,
          ExcTaken, EPCWrite, EPCSrc, ExcCause, KernelMode, StateOut};
    return o;
  endfunction

  // One clock: drive at the falling edge, check 1 ns later
  task automatic step(input logic rdy, input logic irq_v, input obs_t exp, input string tag);
    obs_t act, e;
    @(negedge clk);
    reset = 1'b1; OpCode = cur_op; Funct = cur_fn; Overflow = cur_ov;
    MemReady = rdy; Irq = irq_v;
    #1;
    act = sample();
    e = exp;
    if (e.st != ST_EX) begin
      act.aluop = '0; act.extop = 1'b0; act.luiop = 1'b0;
      e.aluop = '0;   e.extop = 1'b0;   e.luiop = 1'b0;
    end
    n_assert++;
    assert (act === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, e);
    end
  endtask

  task automatic exc(input logic [1:0] c, input string tag);
    obs_t e;
    e = base(ST_EXC);
    e.pcw = 1'b1; e.exct = 1'b1; e.epcw = 1'b1; e.epcsrc = (c != 2'd0);
    step(1'b0, 1'b0, e, tag);
    m_cause = c;
    m_km = 1'b1;
  endtask

  task automatic mem_wait(input obs_t stall, input int unsigned waits, input logic irq_v,
                          input string tag, output bit timed_out);
    timed_out = 1'b0;
    for (int unsigned i = 0; i < waits; i++) begin
      step(1'b0, irq_v, stall, tag);
      if (TO != 0 && i == TO) begin
        exc(2'd3, {tag, "-timeout"});
        timed_out = 1'b1;
        return;
      end
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                       input logic irq, input int unsigned wif, input int unsigned wmem,
                       input bit rst_mrd, input string nm);
    obs_t e, act;
    bit to;
    bit is_r;
    cur_op = op; cur_fn = fn; cur_ov = ov;
    is_r = (op == 6'h00);
    if (irq && !m_km) begin
      e = base(ST_IF);
      step(1'b1, 1'b1, e, {nm, "/IF-irq"});
      exc(2'd0, {nm, "/EXC-irq"});
      return;
    end
    e = base(ST_IF); e.memr = 1'b1; e.srcb = 2'b01;
    mem_wait(e, wif, irq, {nm, "/IF-wait"}, to);
    if (to) return;
    e.irw = 1'b1; e.pcw = 1'b1;
    step(1'b1, irq, e, {nm, "/IF"});
    e = base(ST_ID); e.srcb = 2'b11;
    step(1'b0, 1'b0, e, {nm, "/ID"});
    if (!legal(op, fn) || (op == 6'h10 && !m_km)) begin
      exc(2'd2, {nm, "/EXC-undef"});
      return;
    end
    e = base(ST_EX);
    e.aluop = {op[0], alu_lo(op)};
    e.extop = !(op == 6'h0C || op == 6'h0D);
    e.luiop = (op == 6'h0F);
    if (is_r) e.srca = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
    else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B}) begin
      e.srca = 2'b01; e.srcb = 2'b10;
    end else if (op == 6'h04) begin
      e.pcwc = 1'b1; e.srca = 2'b01; e.pcsrc = 2'b01;
    end else if (op == 6'h02 || op == 6'h03) begin
      e.pcw = 1'b1; e.pcsrc = 2'b11;
      if (op == 6'h03) begin e.regw = 1'b1; e.regdst = 2'b10; e.pcord = 1'b1; end
    end
    step(1'b0, 1'b0, e, {nm, "/EX"});
    if (op inside {6'h02, 6'h03, 6'h04}) return;
    if (op == 6'h10) begin
      e = base(ST_ERT); e.pcw = 1'b1; e.pcsrc = 2'b10;
      step(1'b0, 1'b0, e, {nm, "/ERT"});
      m_km = 1'b0;
      return;
    end
    if (is_r && (fn == 6'h08 || fn == 6'h09)) begin
      e = base(ST_JR); e.pcw = 1'b1; e.pcsrc = 2'b01;
      if (fn == 6'h09) begin e.regw = 1'b1; e.regdst = 2'b01; e.pcord = 1'b1; end
      step(1'b0, 1'b0, e, {nm, "/JR"});
      return;
    end
    if (ov && ((is_r && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08)) begin
      exc(2'd1, {nm, "/EXC-ovf"});
      return;
    end
    if (op == 6'h23) begin
      e = base(ST_MRD); e.iord = 1'b1; e.memr = 1'b1;
      if (rst_mrd) begin
        @(negedge clk);
        reset = 1'b0; MemReady = 1'b0;
        #1;
        act = sample();
        n_assert++;
        assert (act === obs_t'('0)) else begin
          n_fail++;
          $error("FAIL %s/MRD-reset: observed %h expected %h", nm, act, obs_t'('0));
        end
        m_km = 1'b0; m_cause = '0;
        return;
      end
      mem_wait(e, wmem, 1'b0, {nm, "/MRD-wait"}, to);
      if (to) return;
      step(1'b1, 1'b0, e, {nm, "/MRD"});
      e = base(ST_WBL); e.regw = 1'b1; e.m2r = 1'b1;
      step(1'b0, 1'b0, e, {nm, "/WBL"});
      return;
    end
    if (op == 6'h2B) begin
      e = base(ST_MWR); e.iord = 1'b1; e.memw = 1'b1;
      mem_wait(e, wmem, 1'b0, {nm, "/MWR-wait"}, to);
      if (to) return;
      step(1'b1, 1'b0, e, {nm, "/MWR"});
      return;
    end
    e = base(ST_WB); e.regw = 1'b1; e.regdst = is_r ? 2'b01 : 2'b00;
    step(1'b0, 1'b0, e, {nm, "/WB"});
  endtask

  function automatic int unsigned rnd_wait();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return TO + 1;
    if (r == 1) return TO;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    obs_t act;
    logic [5:0] rfn [15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                             6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] iop [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F};
    logic [5:0] bop [3]  = '{6'h02, 6'h03, 6'h04};

    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      act = sample();
      n_assert++;
      assert (act === obs_t'('0)) else begin
        n_fail++;
        $error("FAIL reset-state: observed %h expected %h", act, obs_t'('0));
      end
    end

    instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 0, 1'b1, "T1-lw-rst");
    instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3, 1'b0, "T2-lw-wait3");
    instr(6'h00, 6'h20, 1'b1, 1'b0, 1, 0, 1'b0, "T3-add-ovf");
    instr(6'h08, 6'h00, 1'b0, 1'b1, 0, 0, 1'b0, "T4-irq-kernel");
    instr(6'h10, 6'h18, 1'b0, 1'b0, 0, 0, 1'b0, "T4-eret");
    instr(6'h00, 6'h21, 1'b0, 1'b1, 0, 0, 1'b0, "T4-irq-user");
    instr(6'h10, 6'h18, 1'b0, 1'b0, 0, 0, 1'b0, "T4-eret2");
    instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, TO + 1, 1'b0, "T5-sw-timeout");
    instr(6'h10, 6'h18, 1'b0, 1'b0, 0, 0, 1'b0, "T5-eret");
    instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, TO, 1'b0, "T5-sw-last");
    instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, 0, 1'b0, "T6-op3F");
    instr(6'h10, 6'h18, 1'b0, 1'b0, 0, 0, 1'b0, "T6-eret-k");
    instr(6'h10, 6'h18, 1'b0, 1'b0, 0, 0, 1'b0, "T6-eret-user");
    instr(6'h10, 6'h18, 1'b0, 1'b0, 0, 0, 1'b0, "T6-eret-k2");
    instr(6'h00, 6'h09, 1'b0, 1'b0, 0, 0, 1'b0, "T6-jalr");
    instr(6'h0C, 6'h00, 1'b1, 1'b0, 0, 0, 1'b0, "andi");
    instr(6'h0F, 6'h00, 1'b0, 1'b0, 2, 0, 1'b0, "lui");
    instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 0, 1'b0, "jal");
    instr(6'h08, 6'h00, 1'b1, 1'b0, 0, 0, 1'b0, "addi-ovf");

    for (int k = 0; k < 300; k++) begin
      int unsigned sel;
      logic [5:0] op, fn;
      logic ov, irq;
      sel = $urandom_range(0, 9);
      fn = '0;
      case (sel)
        0, 1, 2: begin op = 6'h00; fn = rfn[$urandom_range(0, 14)]; end
        3:       op = 6'h23;
        4:       op = 6'h2B;
        5:       op = iop[$urandom_range(0, 6)];
        6:       op = bop[$urandom_range(0, 2)];
        7:       begin op = 6'h10; fn = 6'h18; end
        8:       begin op = 6'h00; fn = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'h09; end
        default: begin
          case ($urandom_range(0, 3))
            0:       op = 6'h3F;
            1:       begin op = 6'h00; fn = 6'h01; end
            2:       begin op = 6'h10; fn = 6'h00; end
            default: op = 6'h0E;
          endcase
        end
      endcase
      ov  = 1'($urandom_range(0, 1));
      irq = ($urandom_range(0, 3) == 0);
      instr(op, fn, ov, irq, rnd_wait(), rnd_wait(), 1'b0, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
